// File: rtl/spi_mem_pkg.sv
// Shared constants, FSM encoding and frame helper for the SPI memory master.
package spi_mem_pkg;

    localparam int FRAME_BITS   = 11;
    localparam int PAYLOAD_BITS = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_RX_WAIT  = 3'd2,
        ST_RX_SHIFT = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    function automatic logic [PAYLOAD_BITS+1:0] frame_word(input logic [1:0]              cmd,
                                                           input logic [PAYLOAD_BITS-1:0] payload);
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/spi_mem_master_if.sv
// Host request/response and SPI pin bundle for spi_mem_master.
interface spi_mem_master_if
    import spi_mem_pkg::*;
#(
    parameter int ADDR_SIZE = 8
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wr;
    logic [ADDR_SIZE-1:0]    req_addr;
    logic [PAYLOAD_BITS-1:0] req_wdata;
    logic                    rsp_valid;
    logic [PAYLOAD_BITS-1:0] rsp_rdata;
    logic                    busy;
    logic                    ss_n;
    logic                    mosi;
    logic                    miso;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, miso,
        output req_ready, rsp_valid, rsp_rdata, busy, ss_n, mosi
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, miso,
        input  req_ready, rsp_valid, rsp_rdata, busy, ss_n, mosi
    );
endinterface

// File: rtl/spi_frame_shifter.sv
// MOSI serialiser, MISO deserialiser and shared down-counting bit counter.
module spi_frame_shifter
    import spi_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_load,
    input  logic [PAYLOAD_BITS+1:0] tx_word,
    input  logic                    tx_en,
    input  logic                    rx_load,
    input  logic                    rx_en,
    input  logic                    miso,
    output logic                    mosi,
    output logic                    done,
    output logic [PAYLOAD_BITS-1:0] rx_byte_next
);
    logic [PAYLOAD_BITS+1:0] tx_sh_q, tx_sh_d;
    logic [PAYLOAD_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    mosi_q, mosi_d;

    assign done         = (bit_cnt_q == 4'd0);
    assign rx_byte_next = {rx_sh_q[PAYLOAD_BITS-2:0], miso};
    assign mosi         = mosi_q;

    // cmd[1] is presented on the load edge and again after the first shift,
    // which gives the leading select bit ahead of the 10-bit word.
    always_comb begin
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        bit_cnt_d = bit_cnt_q;
        mosi_d    = 1'b0;
        if (tx_load) begin
            tx_sh_d   = tx_word;
            bit_cnt_d = 4'(FRAME_BITS - 1);
            mosi_d    = tx_word[PAYLOAD_BITS+1];
        end else if (tx_en && !done) begin
            mosi_d    = tx_sh_q[PAYLOAD_BITS+1];
            tx_sh_d   = {tx_sh_q[PAYLOAD_BITS:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
        end
        if (rx_load) begin
            bit_cnt_d = 4'(PAYLOAD_BITS - 1);
        end else if (rx_en) begin
            rx_sh_d = rx_byte_next;
            if (!done) begin
                bit_cnt_d = bit_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= 1'b0;
        end else begin
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
        end
    end
endmodule

// File: rtl/spi_mem_master.sv
// Turns one host request into the two-frame SPI command sequence of the RAM slave.
//   state       | meaning
//   ST_IDLE     | waiting for a request; the accepting cycle loads frame A
//   ST_SHIFT    | ss_n low, 11 MOSI cycles of cmd + payload
//   ST_RX_WAIT  | ss_n low, RD_GAP cycles of slave turnaround
//   ST_RX_SHIFT | ss_n low, 8 MISO samples
//   ST_GAP      | ss_n high, GAP_CYCLES cycles; the last one loads frame B
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_GAP     = 1,
    parameter int GAP_CYCLES = 3
)(
    input  logic             clk,
    input  logic             rst,
    spi_mem_master_if.master bus
);
    localparam int GAP_MAX = (GAP_CYCLES > RD_GAP) ? GAP_CYCLES : RD_GAP;
    localparam int GW      = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX);
    localparam logic [GW-1:0] GAP_LD    = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] RD_GAP_LD = (RD_GAP > 0) ? GW'(RD_GAP - 1) : '0;

    state_e                  state_q, state_d;
    logic                    frame_b_q, frame_b_d;
    logic                    wr_q, wr_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0] wdata_q, wdata_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PAYLOAD_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    ss_n_q, ss_n_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;

    logic                    tx_load, tx_en, rx_load, rx_en, sh_done, mosi;
    logic [PAYLOAD_BITS+1:0] tx_word;
    logic [PAYLOAD_BITS-1:0] rx_byte_next;

    always_comb begin
        state_d     = state_q;
        frame_b_d   = frame_b_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    wr_d      = bus.req_wr;
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    frame_b_d = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    if (frame_b_q && !wr_q) begin
                        if (RD_GAP == 0) begin
                            state_d = ST_RX_SHIFT;
                        end else begin
                            state_d   = ST_RX_WAIT;
                            gap_cnt_d = RD_GAP_LD;
                        end
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LD;
                    end
                end
            end
            ST_RX_WAIT: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_RX_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_RX_SHIFT: begin
                if (sh_done) begin
                    state_d     = ST_GAP;
                    gap_cnt_d   = GAP_LD;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_byte_next;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (!frame_b_q) begin
                        frame_b_d = 1'b1;
                        state_d   = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Word for whichever frame starts next, built from next-cycle context.
        if (frame_b_d) begin
            tx_word = wr_d ? frame_word(CMD_WR_DATA, wdata_d) : frame_word(CMD_RD_DATA, '0);
        end else begin
            tx_word = wr_d ? frame_word(CMD_WR_ADDR, addr_d) : frame_word(CMD_RD_ADDR, addr_d);
        end

        tx_load     = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
        rx_load     = (state_d == ST_RX_SHIFT) && (state_q != ST_RX_SHIFT);
        tx_en       = (state_q == ST_SHIFT);
        rx_en       = (state_q == ST_RX_SHIFT);
        ss_n_d      = !((state_d == ST_SHIFT) || (state_d == ST_RX_WAIT) || (state_d == ST_RX_SHIFT));
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_b_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gap_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ss_n_q      <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_b_q   <= frame_b_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gap_cnt_q   <= gap_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ss_n_q      <= ss_n_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    spi_frame_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .tx_load      (tx_load),
        .tx_word      (tx_word),
        .tx_en        (tx_en),
        .rx_load      (rx_load),
        .rx_en        (rx_en),
        .miso         (bus.miso),
        .mosi         (mosi),
        .done         (sh_done),
        .rx_byte_next (rx_byte_next)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.ss_n      = ss_n_q;
    assign bus.mosi      = mosi;
endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench: two masters (RD_GAP 1 and 2), each talking to a behavioural SPI RAM slave.
module tb_spi_mem_master;
    import spi_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_mem_master_if #(.ADDR_SIZE(8)) if0 ();
    spi_mem_master_if #(.ADDR_SIZE(8)) if1 ();

    spi_mem_master #(.ADDR_SIZE(8), .RD_GAP(1), .GAP_CYCLES(3)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    spi_mem_master #(.ADDR_SIZE(8), .RD_GAP(2), .GAP_CYCLES(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic       rv [2];
    logic       rw [2];
    logic [7:0] ra [2];
    logic [7:0] rwd [2];
    logic       miso_r [2];
    logic       ssn_w [2], mosi_w [2], rdy_w [2], busy_w [2], rspv_w [2];
    logic [7:0] rspd_w [2];

    assign if0.req_valid = rv[0];  assign if1.req_valid = rv[1];
    assign if0.req_wr    = rw[0];  assign if1.req_wr    = rw[1];
    assign if0.req_addr  = ra[0];  assign if1.req_addr  = ra[1];
    assign if0.req_wdata = rwd[0]; assign if1.req_wdata = rwd[1];
    assign if0.miso      = miso_r[0]; assign if1.miso   = miso_r[1];
    assign ssn_w[0]  = if0.ss_n;      assign ssn_w[1]  = if1.ss_n;
    assign mosi_w[0] = if0.mosi;      assign mosi_w[1] = if1.mosi;
    assign rdy_w[0]  = if0.req_ready; assign rdy_w[1]  = if1.req_ready;
    assign busy_w[0] = if0.busy;      assign busy_w[1] = if1.busy;
    assign rspv_w[0] = if0.rsp_valid; assign rspv_w[1] = if1.rsp_valid;
    assign rspd_w[0] = if0.rsp_rdata; assign rspd_w[1] = if1.rsp_rdata;

    // Behavioural slave state: one set per master.
    int         kc [2];
    int         hi [2];
    int         fidx [2];
    int         rsp_cnt [2];
    logic [10:0] sh [2];
    logic [7:0]  sa [2];
    logic [7:0]  txb [2];
    logic        txon [2];
    logic [10:0] frm [2][8];
    int          flen [2][8];
    int          gbef [2][8];
    logic [7:0]  mem [2][256];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int sd(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    function automatic logic [10:0] fw(input logic [1:0] cmd, input logic [7:0] pl);
        return {cmd[1], cmd, pl};
    endfunction

    always @(negedge clk) begin
        int d;
        for (int s = 0; s < 2; s++) begin
            if (rspv_w[s]) rsp_cnt[s]++;
            if (!ssn_w[s]) begin
                if (kc[s] == 0) gbef[s][fidx[s] % 8] = hi[s];
                if (kc[s] <= 10) sh[s] = {sh[s][9:0], mosi_w[s]};
                if (kc[s] == 10) begin
                    case (sh[s][9:8])
                        2'b00, 2'b10: sa[s] = sh[s][7:0];
                        2'b01:        mem[s][sa[s]] = sh[s][7:0];
                        default: begin
                            txb[s]  = mem[s][sa[s]];
                            txon[s] = 1'b1;
                        end
                    endcase
                end
                d = kc[s] - 11 - sd(s);
                miso_r[s] = (txon[s] && d >= 0 && d < 8) ? txb[s][7-d] : 1'b0;
                kc[s]++;
            end else begin
                if (kc[s] != 0) begin
                    frm[s][fidx[s] % 8]  = sh[s];
                    flen[s][fidx[s] % 8] = kc[s];
                    fidx[s]++;
                    kc[s]   = 0;
                    hi[s]   = 0;
                    txon[s] = 1'b0;
                end
                hi[s]++;
                miso_r[s] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_accept(input int s, output int low, output bit acc);
        logic r;
        low = 0;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            r = rdy_w[s];
            @(posedge clk);
            if (r) acc = 1'b1;
            else   low++;
        end
    endtask

    task automatic wait_ready(input int s, output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (rdy_w[s]) seen = 1'b1;
            else          lat++;
        end
    endtask

    task automatic do_txn(input int s, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input int exp_lat, input string tag);
        int low, lat;
        bit acc;
        @(posedge clk);
        #1;
        rv[s] = 1'b1; rw[s] = wr; ra[s] = a; rwd[s] = d;
        wait_accept(s, low, acc);
        #1 rv[s] = 1'b0;
        chk({tag, "_acc"}, 32'(acc), 32'd1);
        wait_ready(s, lat);
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b, f, rc, low, lat;
        bit acc;
        for (int s = 0; s < 2; s++) begin
            rv[s] = 1'b0; rw[s] = 1'b0; ra[s] = '0; rwd[s] = '0;
            kc[s] = 0; hi[s] = 0; fidx[s] = 0; rsp_cnt[s] = 0; txon[s] = 1'b0; sa[s] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_n",   32'(ssn_w[0]),  32'd1);
        chk("rst_mosi",   32'(mosi_w[0]), 32'd0);
        chk("rst_ready",  32'(rdy_w[0]),  32'd0);
        chk("rst_busy",   32'(busy_w[0]), 32'd0);
        chk("rst_rspv",   32'(rspv_w[0]), 32'd0);
        chk("rst_rdata",  32'(rspd_w[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_ready", 32'(rdy_w[0]),  32'd1);
        chk("idle_busy",  32'(busy_w[0]), 32'd0);
        f = fidx[0];
        repeat (10) @(negedge clk);
        chk("idle_frames", fidx[0] - f, 0);
        chk("idle_ss_n",  32'(ssn_w[0]),  32'd1);
        chk("idle_mosi",  32'(mosi_w[0]), 32'd0);

        // write F0/A5: frame bit patterns and inter-frame gap
        b = fidx[0];
        do_txn(0, 1'b1, 8'hF0, 8'hA5, 28, "wr1");
        chk("wr1_frmA", frm[0][b % 8],       11'b000_1111_0000);
        chk("wr1_frmB", frm[0][(b+1) % 8],   11'b001_1010_0101);
        chk("wr1_lenA", flen[0][b % 8],      11);
        chk("wr1_lenB", flen[0][(b+1) % 8],  11);
        chk("wr1_gap",  gbef[0][(b+1) % 8],  3);

        do_txn(0, 1'b1, 8'h0F, 8'hFF, 28, "wr2");
        b  = fidx[0];
        rc = rsp_cnt[0];
        do_txn(0, 1'b0, 8'h0F, 8'h00, 37, "rd1");
        chk("rd1_rdata", 32'(rspd_w[0]), 32'hFF);
        chk("rd1_pulse", rsp_cnt[0] - rc, 1);
        chk("rd1_frmA",  frm[0][b % 8],      fw(CMD_RD_ADDR, 8'h0F));
        chk("rd1_frmB",  frm[0][(b+1) % 8],  fw(CMD_RD_DATA, 8'h00));
        chk("rd1_lenB",  flen[0][(b+1) % 8], 20);

        do_txn(0, 1'b1, 8'h33, 8'h44, 28, "wr3");
        chk("rdata_hold", 32'(rspd_w[0]), 32'hFF);

        // back-to-back: read request held while the write is in flight
        @(posedge clk);
        #1;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'hF0; rwd[0] = 8'h5A;
        wait_accept(0, low, acc);
        #1 rw[0] = 1'b0;
        chk("b2b_acc1", 32'(acc), 32'd1);
        rc = rsp_cnt[0];
        wait_accept(0, low, acc);
        #1 rv[0] = 1'b0;
        chk("b2b_acc2", 32'(acc), 32'd1);
        chk("b2b_wait", low, 28);
        wait_ready(0, lat);
        chk("b2b_lat",   lat, 37);
        chk("b2b_rdata", 32'(rspd_w[0]), 32'h5A);
        chk("b2b_pulse", rsp_cnt[0] - rc, 1);

        // reset at k=5 of read frame B
        rc = rsp_cnt[0];
        @(posedge clk);
        #1;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 8'h0F;
        wait_accept(0, low, acc);
        #1 rv[0] = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstk5_ss_low", 32'(ssn_w[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstk5_ss_n", 32'(ssn_w[0]),  32'd1);
        chk("rstk5_mosi", 32'(mosi_w[0]), 32'd0);
        chk("rstk5_busy", 32'(busy_w[0]), 32'd0);
        repeat (40) @(negedge clk);
        chk("rstk5_len",    flen[0][(fidx[0]-1) % 8], 6);
        chk("rstk5_norsp",  rsp_cnt[0] - rc, 0);
        chk("rstk5_ready",  32'(rdy_w[0]), 32'd1);
        b = fidx[0];
        do_txn(0, 1'b1, 8'h22, 8'h77, 28, "wr_post");
        chk("wr_post_frmA", frm[0][b % 8],     fw(CMD_WR_ADDR, 8'h22));
        chk("wr_post_frmB", frm[0][(b+1) % 8], fw(CMD_WR_DATA, 8'h77));

        // RD_GAP=2 master with a slave that delays MISO by 2
        do_txn(1, 1'b1, 8'h55, 8'h3C, 28, "g2_wr");
        b  = fidx[1];
        rc = rsp_cnt[1];
        do_txn(1, 1'b0, 8'h55, 8'h00, 38, "g2_rd");
        chk("g2_rdata", 32'(rspd_w[1]), 32'h3C);
        chk("g2_lenB",  flen[1][(b+1) % 8], 21);
        chk("g2_pulse", rsp_cnt[1] - rc, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
